// File: rtl/clock_ctrl_pkg.sv
// Shared encodings, field widths and limits for the clock timekeeping block.
// Latency: n/a (constants and one pure function).
// Backpressure: n/a.
package clock_ctrl_pkg;

    localparam int HR_W   = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int MODE_W = 2;

    // Mode register encodings; 2'd3 is never produced.
    localparam logic [MODE_W-1:0] MODE_RUN     = 2'd0;
    localparam logic [MODE_W-1:0] MODE_SET_HR  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_SET_MIN = 2'd2;

    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    // Increment with wrap to zero after max (used for the 0..59 fields).
    function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronises a raw asynchronous button and emits a one-cycle rising-edge pulse.
// Latency: pulse is high in the cycle after the 2nd sampling edge (acts on the 3rd edge).
// Backpressure: none; a held button yields exactly one pulse.
//
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   btn_in in  raw button level, asynchronous to clk
//   pulse  out one-cycle pulse on a synchronised rising edge
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Pulse is internal only; the consumer registers everything it drives out.
    assign pulse = sync2 & ~hist;

endmodule

// File: rtl/clock_time_ctrl.sv
// hh:mm:ss timekeeper with 1 Hz prescaler and RUN/SET_HR/SET_MIN button control.
// Latency: tick and time fields update on the same edge; button action on the 3rd edge after sampling.
// Backpressure: none; buttons are edge-detected, mode change wins over a same-cycle increment.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   btn_mode, btn_inc raw asynchronous push-buttons
//   hours/minutes/seconds  binary time fields
//   mode              0=RUN 1=SET_HR 2=SET_MIN
//   tick_1hz          one-cycle pulse every TICKS_PER_SEC cycles
//   blink             blink enable for the field being set
module clock_time_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic [HR_W-1:0]   hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic [MODE_W-1:0] mode,
    output logic              tick_1hz,
    output logic              blink
);

    localparam int              PW       = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] pre;
    logic          pre_wrap;
    logic          mode_pulse;
    logic          inc_pulse;

    btn_sync_edge u_mode_btn (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_mode),
        .pulse  (mode_pulse)
    );

    btn_sync_edge u_inc_btn (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_inc),
        .pulse  (inc_pulse)
    );

    // Registered tick follows the cycle in which the prescaler holds its last value,
    // so time fields advance on the same edge that raises tick_1hz.
    assign pre_wrap = (pre == PRE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre      <= '0;
            tick_1hz <= 1'b0;
            hours    <= '0;
            minutes  <= '0;
            seconds  <= '0;
            mode     <= MODE_RUN;
            blink    <= 1'b0;
        end else begin
            tick_1hz <= pre_wrap;
            pre      <= pre_wrap ? '0 : pre + 1'b1;

            if (mode_pulse) begin
                // Mode change takes priority; a same-cycle increment is dropped.
                case (mode)
                    MODE_RUN: begin
                        mode  <= MODE_SET_HR;
                        blink <= 1'b1;
                    end
                    MODE_SET_HR: begin
                        mode  <= MODE_SET_MIN;
                        blink <= 1'b1;
                    end
                    default: begin
                        // Leaving set mode restarts the second from zero.
                        mode    <= MODE_RUN;
                        blink   <= 1'b0;
                        seconds <= '0;
                        pre     <= '0;
                    end
                endcase
            end else begin
                case (mode)
                    MODE_RUN: begin
                        if (pre_wrap) begin
                            seconds <= inc_wrap6(seconds, SEC_MAX);
                            if (seconds == SEC_MAX) begin
                                minutes <= inc_wrap6(minutes, MIN_MAX);
                                if (minutes == MIN_MAX) begin
                                    hours <= (hours == HR_MAX) ? '0 : hours + 1'b1;
                                end
                            end
                        end
                    end
                    MODE_SET_HR: begin
                        if (inc_pulse) begin
                            hours <= (hours == HR_MAX) ? '0 : hours + 1'b1;
                        end
                        if (pre_wrap) begin
                            blink <= ~blink;
                        end
                    end
                    default: begin
                        if (inc_pulse) begin
                            minutes <= inc_wrap6(minutes, MIN_MAX);
                        end
                        if (pre_wrap) begin
                            blink <= ~blink;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench for clock_time_ctrl with TICKS_PER_SEC=4.
// Stimulus pushes expected snapshots / tick cycles into queues; one monitor
// pops and compares them on the falling clock edge.
module tb_clock_time_ctrl;

    localparam int TPS = 4;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       tick_1hz;
    logic       blink;

    clock_time_ctrl #(.TICKS_PER_SEC(TPS)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .mode     (mode),
        .tick_1hz (tick_1hz),
        .blink    (blink)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected snapshot; a field of -1 is not compared.
    typedef struct {
        string name;
        int    h;
        int    m;
        int    s;
        int    md;
        int    bl;
        int    tk;
    } exp_t;

    exp_t exp_q[$];
    int   tick_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   tick_from = 0;
    logic tick_en = 1'b0;
    logic tick_close = 1'b0;

    // Edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares all pending snapshots and any tick in the enabled window.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.h  >= 0) chk({e.name, ".hours"},   int'(hours),    e.h);
            if (e.m  >= 0) chk({e.name, ".minutes"}, int'(minutes),  e.m);
            if (e.s  >= 0) chk({e.name, ".seconds"}, int'(seconds),  e.s);
            if (e.md >= 0) chk({e.name, ".mode"},    int'(mode),     e.md);
            if (e.bl >= 0) chk({e.name, ".blink"},   int'(blink),    e.bl);
            if (e.tk >= 0) chk({e.name, ".tick"},    int'(tick_1hz), e.tk);
        end
        if (tick_en && !rst && cyc > tick_from && tick_1hz) begin
            if (tick_q.size() == 0) chk("tick_unexpected_at_cycle", cyc, -1);
            else                    chk("tick_cycle", cyc, tick_q.pop_front());
        end
        if (tick_close) begin
            chk("tick_missing_count", tick_q.size(), 0);
            tick_q.delete();
        end
    end

    task automatic push(input string n, input int h, input int m, input int s,
                        input int md, input int bl, input int tk);
        exp_t e;
        e.name = n; e.h = h; e.m = m; e.s = s; e.md = md; e.bl = bl; e.tk = tk;
        exp_q.push_back(e);
    endtask

    // Asserts reset between edges; outputs must clear without a clock edge.
    task automatic do_reset(input string n);
        rst = 1'b1;
        #1;
        push(n, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    // Raise buttons just after a falling edge; return #1 after the 3rd rising edge.
    task automatic btn_down(input logic m, input logic i);
        @(negedge clk);
        #1;
        if (m) btn_mode = 1'b1;
        if (i) btn_inc  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic btn_up();
        @(negedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic press_n(input logic m, input int n);
        for (int i = 0; i < n; i++) begin
            btn_down(m, ~m);
            btn_up();
        end
    endtask

    task automatic close_ticks();
        tick_close = 1'b1;
        @(negedge clk);
        #1;
        tick_close = 1'b0;
        tick_en    = 1'b0;
    endtask

    int m0;

    initial begin
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        rst      = 1'b0;

        // 1. Free run for one minute; ticks every 4 cycles starting at cycle 4.
        do_reset("reset0");
        tick_from = 0;
        for (int k = 1; k <= 60; k++) tick_q.push_back(k * TPS);
        tick_en = 1'b1;
        for (int k = 1; k <= 60 * TPS; k++) begin
            @(posedge clk);
            #1;
            if (k == 1)   push("run_c1",   0, 0, 0,  0, 0, 0);
            if (k == 4)   push("run_c4",   0, 0, 1,  0, 0, 1);
            if (k == 236) push("run_c236", 0, 0, 59, 0, 0, 1);
            if (k == 240) push("run_c240", 0, 1, 0,  0, 0, 1);
        end
        close_ticks();

        // 2. Set 23:59, return to RUN, count up to 23:59:59 and roll over.
        do_reset("reset1");
        press_n(1'b1, 1);
        push("t2_sethr", 0, 0, 0, 1, -1, -1);
        press_n(1'b0, 23);
        push("t2_hr23", 23, 0, 0, 1, -1, -1);
        press_n(1'b1, 1);
        push("t2_setmin", 23, 0, 0, 2, 1, -1);
        press_n(1'b0, 59);
        push("t2_min59", 23, 59, 0, 2, -1, -1);
        btn_down(1'b1, 1'b0);
        push("t2_run", 23, 59, 0, 0, 0, -1);
        for (int k = 1; k <= 60 * TPS; k++) begin
            @(posedge clk);
            #1;
            if (k >= 236 && k < 240) push("t2_235959", 23, 59, 59, 0, 0, -1);
            if (k == 240)            push("t2_wrap",    0,  0,  0,  0, 0, 1);
        end
        btn_up();

        // 3. Enter SET_HR, 25 increments wrap to hours=1; time stays frozen.
        do_reset("reset2");
        btn_down(1'b1, 1'b0);
        push("t3_enter", 0, 0, 0, 1, 1, -1);
        btn_up();
        press_n(1'b0, 25);
        push("t3_hr1", 1, 0, 0, 1, -1, -1);

        // 4. SET_MIN wrap 59->0 without hour carry, then back to RUN.
        btn_down(1'b1, 1'b0);
        push("t4_enter", 1, 0, 0, 2, 1, -1);
        btn_up();
        press_n(1'b0, 59);
        push("t4_min59", 1, 59, 0, 2, -1, -1);
        press_n(1'b0, 1);
        push("t4_minwrap", 1, 0, 0, 2, -1, -1);
        btn_down(1'b1, 1'b0);
        push("t4_run", 1, 0, 0, 0, 0, -1);
        m0 = cyc;
        tick_from = m0;
        tick_q.push_back(m0 + TPS);
        tick_q.push_back(m0 + 2 * TPS);
        tick_en = 1'b1;
        for (int k = 1; k <= 2 * TPS; k++) begin
            @(posedge clk);
            #1;
            if (k == TPS - 1) push("t4_pre_tick", 1, 0, 0, 0, 0, 0);
            if (k == TPS)     push("t4_tick",     1, 0, 1, 0, 0, 1);
        end
        close_ticks();
        btn_up();

        // 5. Simultaneous mode+inc in SET_HR: mode wins. Then a 20-cycle inc hold.
        do_reset("reset3");
        press_n(1'b1, 1);
        push("t5_sethr", 0, 0, 0, 1, -1, -1);
        btn_down(1'b1, 1'b1);
        push("t5_both", 0, 0, 0, 2, 1, -1);
        btn_up();
        btn_down(1'b0, 1'b1);
        push("t5_hold_first", 0, 1, 0, 2, -1, -1);
        repeat (17) @(posedge clk);
        #1;
        push("t5_hold_end", 0, 1, 0, 2, -1, -1);
        btn_up();

        // 6. Asynchronous reset in SET_MIN between clock edges.
        @(posedge clk);
        #1;
        do_reset("t6_async_rst");
        repeat (2) @(posedge clk);
        #1;
        push("t6_after", 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
